// File: rtl/pipe_exe_div.sv
// Iterative restoring divider for MIPS DIV/DIVU in the EXE stage.
// One quotient bit per cycle; stalls the ID/EXE register until the result is ready.
module pipe_exe_div #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e             r_state;
  state_e             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dsr;
  logic [WIDTH-1:0]   r_raw;
  logic               r_q_neg;
  logic               r_r_neg;
  logic               r_dsr_zero;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_div_zero;
  logic               r_busy;
  logic               r_done;

  logic               w_dvd_neg;
  logic               w_dsr_neg;
  logic [WIDTH-1:0]   w_dvd_mag;
  logic [WIDTH-1:0]   w_dsr_mag;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_diff_neg;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;

  assign w_dvd_neg = is_signed & dividend[WIDTH-1];
  assign w_dsr_neg = is_signed & divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
  assign w_dsr_mag = w_dsr_neg ? -divisor : divisor;

  // Remainder stays below the divisor, so WIDTH+1 bits hold both the shifted value and the sign.
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_dsr};
  assign w_diff_neg = w_diff[WIDTH];

  assign w_q_fix = r_q_neg ? -r_quo : r_quo;
  assign w_r_fix = r_r_neg ? -r_rem : r_rem;

  always_comb begin
    w_state_next = r_state;
    stall        = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_next = StRun;
          stall        = 1'b1;
        end
      end
      StRun: begin
        stall = 1'b1;
        if (&r_cnt) w_state_next = StFix;
      end
      StFix: begin
        stall        = 1'b1;
        w_state_next = StDone;
      end
      StDone: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dsr       <= '0;
      r_raw       <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_dsr_zero  <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == StRun) || (w_state_next == StFix);
      r_done  <= (w_state_next == StDone);
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= w_dvd_mag;
            r_dsr      <= w_dsr_mag;
            r_raw      <= dividend;
            r_q_neg    <= w_dvd_neg ^ w_dsr_neg;
            r_r_neg    <= w_dvd_neg;
            r_dsr_zero <= (divisor == '0);
          end
        end
        StRun: begin
          r_cnt <= r_cnt + CNT_W'(1);
          r_quo <= {r_quo[WIDTH-2:0], ~w_diff_neg};
          r_rem <= w_diff_neg ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
        end
        StFix: begin
          if (r_dsr_zero) begin
            r_quotient  <= '1;
            r_remainder <= r_raw;
            r_div_zero  <= 1'b1;
          end else begin
            r_quotient  <= w_q_fix;
            r_remainder <= w_r_fix;
            r_div_zero  <= 1'b0;
          end
        end
        StDone: ;
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_pipe_exe_div.sv
// Bench for pipe_exe_div: table of divisions checked through a result scoreboard,
// plus hand-written reset-abort and held-start sequences.
module tb_pipe_exe_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  pipe_exe_div #(.WIDTH(32), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t exp_q[$];
  vec_t vecs[10];
  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      vec_t e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
      end
    end
  end

  task automatic do_div(input vec_t v);
    int lat;
    int stalls;
    @(negedge clk);
    start     = 1'b1;
    is_signed = v.sgn;
    dividend  = v.a;
    divisor   = v.b;
    exp_q.push_back(v);
    lat    = 0;
    stalls = 0;
    #1;
    while (lat < 100) begin
      if (stall) stalls++;
      if (done) break;
      @(negedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    check("latency", lat, 32'd34);
    check("stall_cycles", stalls, 32'd34);
    // Results must hold through the following idle cycles.
    repeat (2) @(negedge clk);
    check("quotient_held", quotient, v.q);
    check("div_zero_held", {31'd0, div_zero}, {31'd0, v.dz});
  endtask

  initial begin
    int n;
    int first_done;
    int second_done;
    vec_t v;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
    vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[5] = '{1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1'b1};
    vecs[6] = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
    vecs[7] = '{1'b0, 32'hDEAD_BEEF,  32'h0000_1000,  32'h000D_EADB,  32'h0000_0EEF,  1'b0};
    vecs[8] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0};
    vecs[9] = '{1'b1, 32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  32'h8000_0000,  1'b1};

    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_div_zero", {31'd0, div_zero}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) do_div(vecs[i]);

    // Abort a division with reset 10 cycles after start.
    @(negedge clk);
    start     = 1'b1;
    is_signed = 1'b0;
    dividend  = 32'd50;
    divisor   = 32'd5;
    repeat (10) @(negedge clk);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_stall", {31'd0, stall}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_quotient", quotient, 32'd0);
    n = done_cnt;
    repeat (40) @(negedge clk);
    check("abort_no_done", done_cnt - n, 32'd0);
    do_div('{1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0});

    // start held for 40 cycles: one division, then a second from the following IDLE.
    v = '{1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0};
    @(negedge clk);
    start     = 1'b1;
    is_signed = v.sgn;
    dividend  = v.a;
    divisor   = v.b;
    exp_q.push_back(v);
    exp_q.push_back(v);
    n           = 0;
    first_done  = -1;
    second_done = -1;
    for (int c = 0; c < 110; c++) begin
      if (c == 40) start = 1'b0;
      #1;
      if (done) begin
        if (c < 35) n++;
        if (first_done < 0) first_done = c;
        else if (second_done < 0) second_done = c;
      end
      if (second_done >= 0) break;
      @(negedge clk);
    end
    check("hold_done_in_35", n, 32'd1);
    check("hold_first_done", first_done, 32'd34);
    check("hold_second_done", second_done, 32'd69);
    repeat (3) @(negedge clk);
    check("sb_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
